// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel tone divider: note half-period table and the
// half-period derivation used by every channel.
package clk_div_pkg;

  localparam int unsigned DefNumCh    = 4;
  localparam int unsigned DefSelW     = 3;
  localparam int unsigned DefCntW     = 16;
  localparam int unsigned DefDivShift = 0;

  localparam int unsigned NoteEntries = 8;

  // Half-periods in 50 MHz cycles: 25_000_000 / f, floored.
  localparam logic [DefCntW-1:0] NOTE_HALF_PERIOD [NoteEntries] = '{
    16'd47801,  // Do  523 Hz
    16'd42589,  // Re  587 Hz
    16'd37936,  // Mi  659 Hz
    16'd35816,  // Fa  698 Hz
    16'd31928,  // So  783 Hz
    16'd28409,  // La  880 Hz
    16'd25329,  // Si  987 Hz
    16'd23900   // Do' 1046 Hz
  };

  // Selects past the table repeat the last entry; shifted result never drops below 1.
  function automatic int unsigned half_of(input int unsigned sel, input int unsigned shift);
    logic [2:0]  idx;
    int unsigned raw;
    idx = (sel >= NoteEntries) ? 3'(NoteEntries - 1) : 3'(sel);
    raw = 32'(NOTE_HALF_PERIOD[idx]);
    raw = (shift >= 32) ? 0 : (raw >> shift);
    return (raw == 0) ? 1 : raw;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, output toggle and select latch sampled only at
// toggle points. Optional rising-edge strobe when CLKDIV_TICK_EN is defined.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned SEL_W     = DefSelW,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned DIV_SHIFT = DefDivShift
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic             o_tick
`endif
);

  localparam logic [CNT_W-1:0] HalfRst = CNT_W'(half_of(0, DIV_SHIFT));

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] w_half_nxt;
  logic [CNT_W-1:0] w_half_sel;
  logic             r_out;
  logic             w_out_nxt;
  logic             w_wrap;

  assign w_half_sel = CNT_W'(half_of(32'(i_sel), DIV_SHIFT));
  assign w_wrap     = (r_cnt == (r_half - CNT_W'(1)));

  // Select is only latched at a toggle (or while idle), so a level is never cut short.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_out_nxt  = r_out;
    w_half_nxt = r_half;
    if (!i_en) begin
      w_cnt_nxt  = '0;
      w_out_nxt  = 1'b0;
      w_half_nxt = w_half_sel;
    end else if (w_wrap) begin
      w_cnt_nxt  = '0;
      w_out_nxt  = ~r_out;
      w_half_nxt = w_half_sel;
    end else begin
      w_cnt_nxt  = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_half <= HalfRst;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_out  <= w_out_nxt;
      r_half <= w_half_nxt;
    end
  end

  assign o_out = r_out;

`ifdef CLKDIV_TICK_EN
  logic r_tick;
  logic w_tick_nxt;

  assign w_tick_nxt = i_en & w_wrap & ~r_out;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick_nxt;
    end
  end

  assign o_tick = r_tick;
`endif

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel tone clock divider: NUM_CH independent square-wave outputs from inclk.
// Define CLKDIV_TICK_EN to add the per-channel rising-edge tick output.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH    = DefNumCh,
  parameter int unsigned SEL_W     = DefSelW,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned DIV_SHIFT = DefDivShift
) (
  input  logic                    inclk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*SEL_W-1:0] frequency_sel,
  output logic [NUM_CH-1:0]       outclk
`ifdef CLKDIV_TICK_EN
  ,
  output logic [NUM_CH-1:0]       tick
`endif
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_channel #(
      .SEL_W     (SEL_W),
      .CNT_W     (CNT_W),
      .DIV_SHIFT (DIV_SHIFT)
    ) u_ch (
      .i_clk   (inclk),
      .i_rst_n (reset_n),
      .i_en    (enable[k]),
      .i_sel   (frequency_sel[k*SEL_W +: SEL_W]),
      .o_out   (outclk[k])
`ifdef CLKDIV_TICK_EN
      ,
      .o_tick  (tick[k])
`endif
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: three instances at DIV_SHIFT 0, 8 and 16.
module tb_clk_divider_multi;

  logic        clk;
  logic        rst0_n, rst8_n, rst16_n;
  logic [3:0]  en0, en8, en16;
  logic [11:0] sel0, sel8, sel16;
  logic [3:0]  oc0, oc8, oc16;
  logic [3:0]  tk0, tk8, tk16;

  int n_checks = 0;
  int n_pass   = 0;

  int edge_t [4][40];
  int edge_n [4];
  int tick_n [4];
  int tick_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  clk_divider_multi #(.NUM_CH(4), .SEL_W(3), .CNT_W(16), .DIV_SHIFT(0)) dut0 (
    .inclk         (clk),
    .reset_n       (rst0_n),
    .enable        (en0),
    .frequency_sel (sel0),
    .outclk        (oc0)
`ifdef CLKDIV_TICK_EN
    ,
    .tick          (tk0)
`endif
  );

  clk_divider_multi #(.NUM_CH(4), .SEL_W(3), .CNT_W(16), .DIV_SHIFT(8)) dut8 (
    .inclk         (clk),
    .reset_n       (rst8_n),
    .enable        (en8),
    .frequency_sel (sel8),
    .outclk        (oc8)
`ifdef CLKDIV_TICK_EN
    ,
    .tick          (tk8)
`endif
  );

  clk_divider_multi #(.NUM_CH(4), .SEL_W(3), .CNT_W(16), .DIV_SHIFT(16)) dut16 (
    .inclk         (clk),
    .reset_n       (rst16_n),
    .enable        (en16),
    .frequency_sel (sel16),
    .outclk        (oc16)
`ifdef CLKDIV_TICK_EN
    ,
    .tick          (tk16)
`endif
  );

`ifndef CLKDIV_TICK_EN
  assign tk0  = 4'b0;
  assign tk8  = 4'b0;
  assign tk16 = 4'b0;
`endif

  function automatic logic [3:0] get_oc(input int d);
    if (d == 0) return oc0;
    if (d == 8) return oc8;
    return oc16;
  endfunction

  function automatic logic [3:0] get_tk(input int d);
    if (d == 0) return tk0;
    if (d == 8) return tk8;
    return tk16;
  endfunction

  task automatic drive(input int d, input logic rst, input logic [11:0] s, input logic [3:0] e);
    if (d == 0) begin rst0_n = rst; sel0 = s; en0 = e; end
    else if (d == 8) begin rst8_n = rst; sel8 = s; en8 = e; end
    else begin rst16_n = rst; sel16 = s; en16 = e; end
  endtask

  // Reset, release with enable low for a cycle (loads half(sel)), then enable at a negedge.
  task automatic start(input int d, input logic [11:0] s, input logic [3:0] e);
    @(negedge clk);
    drive(d, 1'b0, s, 4'b0);
    @(negedge clk);
    drive(d, 1'b1, s, 4'b0);
    @(negedge clk);
    drive(d, 1'b1, s, e);
  endtask

  // n = posedges elapsed until channel ch is seen at lvl (sampled on negedges).
  task automatic wait_level(input int d, input int ch, input logic lvl, input int bound,
                            output int n);
    logic [3:0] v;
    n = 0;
    v = get_oc(d);
    while (v[ch] !== lvl && n < bound) begin
      @(negedge clk);
      n++;
      v = get_oc(d);
    end
  endtask

  // Record the posedge index of every outclk transition over ncyc cycles.
  task automatic record_edges(input int d, input int ncyc);
    logic [3:0] prev, cur, tk;
    for (int ch = 0; ch < 4; ch++) begin
      edge_n[ch] = 0;
      tick_n[ch] = 0;
      for (int i = 0; i < 40; i++) edge_t[ch][i] = -1;
    end
    tick_bad = 0;
    prev = get_oc(d);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cur = get_oc(d);
      tk  = get_tk(d);
      for (int ch = 0; ch < 4; ch++) begin
        if (cur[ch] !== prev[ch]) begin
          if (edge_n[ch] < 40) edge_t[ch][edge_n[ch]] = c;
          edge_n[ch]++;
        end
        if (tk[ch] !== (cur[ch] & ~prev[ch])) tick_bad++;
        if (tk[ch] === 1'b1) tick_n[ch]++;
      end
      prev = cur;
    end
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 12'h0, 4'h0);
    drive(8, 1'b0, 12'h0, 4'h0);
    drive(16, 1'b0, 12'h0, 4'h0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({oc0, oc8, oc16} !== 12'h0) $display("FAIL reset_outclk got %h want 000", {oc0, oc8, oc16});
    else n_pass++;
    n_checks++;
    if ({tk0, tk8, tk16} !== 12'h0) $display("FAIL reset_tick got %h want 000", {tk0, tk8, tk16});
    else n_pass++;
    drive(0, 1'b1, 12'h0, 4'h0);
    drive(8, 1'b1, 12'h0, 4'h0);
    drive(16, 1'b1, 12'h0, 4'h0);
    record_edges(8, 50);
    n_checks++;
    if (edge_n[0] + edge_n[1] + edge_n[2] + edge_n[3] !== 0)
      $display("FAIL disabled_idle got %0d edges want 0",
               edge_n[0] + edge_n[1] + edge_n[2] + edge_n[3]);
    else n_pass++;
  endtask

  // Full-size table: ch0 Do (47801), ch1 Do' (23900).
  task automatic test_full_table();
    start(0, {3'd0, 3'd0, 3'd7, 3'd0}, 4'b0011);
    record_edges(0, 47810);
    n_checks++;
    if (edge_t[0][0] !== 47801) $display("FAIL full_sel0_rise got %0d want 47801", edge_t[0][0]);
    else n_pass++;
    n_checks++;
    if (edge_n[0] !== 1) $display("FAIL full_sel0_edges got %0d want 1", edge_n[0]);
    else n_pass++;
    n_checks++;
    if (edge_t[1][0] !== 23900) $display("FAIL full_sel7_rise got %0d want 23900", edge_t[1][0]);
    else n_pass++;
    n_checks++;
    if (edge_t[1][1] !== 47800) $display("FAIL full_sel7_fall got %0d want 47800", edge_t[1][1]);
    else n_pass++;
    drive(0, 1'b1, 12'h0, 4'b0);
  endtask

  // La at shift 8: half 110, ten periods.
  task automatic test_steady_period();
    start(8, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001);
    record_edges(8, 2205);
    n_checks++;
    if (edge_n[0] !== 20) $display("FAIL steady_edges got %0d want 20", edge_n[0]);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (edge_t[0][i] !== 110 * (i + 1))
        $display("FAIL steady_edge%0d got %0d want %0d", i, edge_t[0][i], 110 * (i + 1));
      else n_pass++;
    end
`ifdef CLKDIV_TICK_EN
    n_checks++;
    if (tick_n[0] !== 10) $display("FAIL steady_tick_count got %0d want 10", tick_n[0]);
    else n_pass++;
    n_checks++;
    if (tick_bad !== 0) $display("FAIL steady_tick_align got %0d bad want 0", tick_bad);
    else n_pass++;
`endif
  endtask

  // Select moves 0 -> 7 fifty cycles into a 186-cycle high level.
  task automatic test_glitch_free_select();
    int n;
    start(8, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0001);
    wait_level(8, 0, 1'b1, 1000, n);
    n_checks++;
    if (n !== 186) $display("FAIL glitch_first_low got %0d want 186", n);
    else n_pass++;
    repeat (50) @(negedge clk);
    sel8 = {3'd0, 3'd0, 3'd0, 3'd7};
    wait_level(8, 0, 1'b0, 1000, n);
    n_checks++;
    if (n !== 136) $display("FAIL glitch_rest_of_high got %0d want 136", n);
    else n_pass++;
    wait_level(8, 0, 1'b1, 1000, n);
    n_checks++;
    if (n !== 93) $display("FAIL glitch_new_low got %0d want 93", n);
    else n_pass++;
    wait_level(8, 0, 1'b0, 1000, n);
    n_checks++;
    if (n !== 93) $display("FAIL glitch_new_high got %0d want 93", n);
    else n_pass++;
  endtask

  // Shift 16 floors every entry to 0, clamped to 1: toggle each cycle.
  task automatic test_min_half();
    start(16, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0001);
    record_edges(16, 20);
    n_checks++;
    if (edge_n[0] !== 20) $display("FAIL min_half_edges got %0d want 20", edge_n[0]);
    else n_pass++;
    n_checks++;
    if (edge_t[0][0] !== 1 || edge_t[0][19] !== 20)
      $display("FAIL min_half_times got %0d,%0d want 1,20", edge_t[0][0], edge_t[0][19]);
    else n_pass++;
`ifdef CLKDIV_TICK_EN
    n_checks++;
    if (tick_n[0] !== 10 || tick_bad !== 0)
      $display("FAIL min_half_tick got %0d/%0d bad want 10/0", tick_n[0], tick_bad);
    else n_pass++;
`endif
  endtask

  task automatic test_four_channels();
    int half [4];
    half = '{186, 148, 124, 93};
    start(8, {3'd7, 3'd4, 3'd2, 3'd0}, 4'b1111);
    record_edges(8, 760);
    for (int ch = 0; ch < 4; ch++) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (edge_t[ch][i] !== half[ch] * (i + 1))
          $display("FAIL multi_ch%0d_edge%0d got %0d want %0d", ch, i, edge_t[ch][i],
                   half[ch] * (i + 1));
        else n_pass++;
      end
    end
`ifdef CLKDIV_TICK_EN
    n_checks++;
    if (tick_bad !== 0) $display("FAIL multi_tick_align got %0d bad want 0", tick_bad);
    else n_pass++;
`endif
  endtask

  task automatic test_enable_and_reset();
    int n;
    start(8, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001);
    wait_level(8, 0, 1'b1, 1000, n);
    n_checks++;
    if (n !== 110) $display("FAIL en_first_rise got %0d want 110", n);
    else n_pass++;
    repeat (20) @(negedge clk);
    en8 = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (oc8[0] !== 1'b0) $display("FAIL en_drop_outclk got %b want 0", oc8[0]);
    else n_pass++;
    n_checks++;
    if (tk8[0] !== 1'b0) $display("FAIL en_drop_tick got %b want 0", tk8[0]);
    else n_pass++;
    en8 = 4'b0001;
    wait_level(8, 0, 1'b1, 1000, n);
    n_checks++;
    if (n !== 110) $display("FAIL en_restart_rise got %0d want 110", n);
    else n_pass++;
    repeat (30) @(negedge clk);
    #2 rst8_n = 1'b0;
    #1;
    n_checks++;
    if (oc8[0] !== 1'b0) $display("FAIL async_reset_outclk got %b want 0", oc8[0]);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst8_n = 1'b1;
    // Reset loads table[0] (186); the select (110) is only picked up at the first toggle.
    wait_level(8, 0, 1'b1, 1000, n);
    n_checks++;
    if (n !== 186) $display("FAIL post_reset_rise got %0d want 186", n);
    else n_pass++;
    wait_level(8, 0, 1'b0, 1000, n);
    n_checks++;
    if (n !== 110) $display("FAIL post_reset_high got %0d want 110", n);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_steady_period();
    test_glitch_free_select();
    test_min_half();
    test_four_channels();
    test_enable_and_reset();
    test_full_table();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Parametrised, multi-channel successor to the single-channel tone clock divider.
- Each channel divides inclk (50 MHz) into a square wave. The frequency comes from a per-channel select index into a note half-period table.
- Select changes take effect glitch-free at the next output edge. Each channel has its own enable.
- Feeds audio/tone outputs and slow-clock consumers in the lab top level.

Parameters:
- NUM_CH, 4, number of independent output channels.
- SEL_W, 3, width of each channel's frequency select; the table has 2**SEL_W entries.
- CNT_W, 16, half-period counter width; must hold the largest table entry.
- DIV_SHIFT, 0, right-shift applied to every table entry (simulation speed-up). Result is floored, minimum 1.

Ports:
- inclk  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  NUM_CH  per-channel run enable.
- frequency_sel  input  NUM_CH*SEL_W  channel k select at bits [k*SEL_W +: SEL_W].
- outclk  output  NUM_CH  divided square-wave outputs.
- tick  output  NUM_CH  one-inclk-cycle strobe at each outclk rising transition; present only with CLKDIV_TICK_EN.

Behaviour:
- Reset (reset_n low, asynchronous), all channels:
  - count=0, outclk=0, tick=0, half_cur=table[0]>>DIV_SHIFT.
- Effective half-period: half(s) = max(1, TABLE[s] >> DIV_SHIFT).
- Per channel, per inclk rising edge, when enable=1:
  - If count == half_cur-1: count<=0, outclk toggles, half_cur<=half(sel).
  - Else count<=count+1.
- Output timing: each outclk level lasts exactly half_cur inclk cycles. Period = 2*half_cur cycles; duty is exactly 50%.
- Glitch-free select: frequency_sel is sampled only at a toggle point. Mid-half-period changes never truncate or extend the current level. The new half-period applies from the next level.
- enable=0: synchronously count<=0, outclk<=0, half_cur<=half(sel) every cycle, so a channel restarts with the current select.
- enable 0->1: first toggle (0->1) occurs after half_cur cycles, so the first rising edge is exactly half_cur cycles after the first enabled edge.
- half_cur==1: outclk toggles every cycle (inclk/2).
- Channels are fully independent; no shared counter.
- Reset mid-operation returns everything to reset values immediately.
- TABLE, half-periods at 50 MHz (25_000_000/f, floored):
  - 0: Do 523 Hz = 47801
  - 1: Re 587 = 42589
  - 2: Mi 659 = 37936
  - 3: Fa 698 = 35816
  - 4: So 783 = 31928
  - 5: La 880 = 28409
  - 6: Si 987 = 25329
  - 7: Do' 1046 = 23900
  - SEL_W>3: entries 8 and up repeat entry 7.
- Latency: outclk is registered; no combinational path from inputs to outclk.

Optional Feature:
- Macro: CLKDIV_TICK_EN.
- Defined:
  - tick[k]=1 for exactly the inclk cycle in which outclk[k] is first observed high after a 0->1 toggle (registered alongside outclk).
  - Never asserted while enable[k]=0 or in reset.
- Undefined:
  - tick port and logic absent.
  - outclk behaviour identical.

Decomposition:
- Shared package clk_div_pkg holds:
  - NOTE_HALF_PERIOD table constant, 8 entries, CNT_W-bit.
  - Function half_of(sel, shift) implementing the max(1, >>) rule.
  - Default-parameter constants.
- Sub-module clk_div_channel: one counter/toggle/select-latch channel. The top generates NUM_CH instances and slices frequency_sel.

Test Plan:
- Reset, DIV_SHIFT=0, enable=4'b0001, sel0=0 -> outclk[0] rises 47801 cycles after enable, falls 47801 later; period 95602 cycles.
- DIV_SHIFT=8, sel0=5 -> half=110; outclk[0] levels exactly 110 cycles each over 10 periods. With CLKDIV_TICK_EN, tick[0] pulses once per 220 cycles.
- DIV_SHIFT=8, sel0 changes 0->7 at cycle 50 of a 186-cycle level -> that level still lasts 186. Subsequent levels last 93. No short pulse.
- DIV_SHIFT=16, sel=0 (half=max(1,0)=1) -> outclk toggles every cycle.
- Four channels enabled, sels 0/2/4/7, DIV_SHIFT=8 -> independent half-periods 186/148/124/93, each verified simultaneously.
- Deassert enable mid-high, then assert reset_n=0 asynchronously mid-count -> outclk=0 next edge (enable) and immediately (reset). After release, restart timing is exact.
